match_controller: RTL and testbench
===================================

Name: match_controller

Overview:
- Downstream of both GameplayController instances; consumes their 4-bit player states once per 60 Hz frame.
- Converts transitions into hitstun/blockstun into health loss and block counts.
- Runs the round countdown, the 99-second round timer, round scoring and match end.
- Drives a freeze signal that holds both gameplay controllers idle outside live play.

Parameters:
- MAX_HEALTH, 3, hits a player absorbs per round (fits 3-bit health)
- FRAMES_PER_SEC, 60, frames per timer second
- ROUND_TIME, 99, round timer start value in seconds (fits 7 bits)
- COUNTDOWN_SEC, 3, pre-round countdown in seconds
- ROUND_END_FRAMES, 120, frames shown in ROUND_END before the next round
- ROUNDS_TO_WIN, 2, rounds needed to take the match

Ports:
- clk_60Hz  in  1  frame clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level input from the board button; internally rising-edge detected
- p1_state  in  4  player-1 state (0 IDLE … 9 HITSTUN, 10 BLOCKSTUN)
- p2_state  in  4  player-2 state, same encoding
- p1_health  out  3  player-1 remaining health
- p2_health  out  3  player-2 remaining health
- p1_rounds  out  2  rounds won by player 1
- p2_rounds  out  2  rounds won by player 2
- round_timer  out  7  seconds remaining; countdown seconds while in COUNTDOWN
- game_phase  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid in ROUND_END and MATCH_OVER
- freeze  out  1  high in every phase except FIGHT; wired into the player controllers' reset
- round_start  out  1  one-cycle pulse on COUNTDOWN→FIGHT
- p1_blocks  out  8  blocks by player 1 this match, saturating at 255
- p2_blocks  out  8  blocks by player 2 this match, saturating at 255

Behaviour:
- Reset values:
  - game_phase=IDLE; freeze=1; round_start=0; winner=00.
  - Both healths = MAX_HEALTH; both rounds = 0; both block counts = 0.
  - round_timer = ROUND_TIME; frame counter = 0; start edge register = 0.
  - Previous-state registers = 0 (IDLE).
- Edge events, evaluated every cycle from registered previous states:
  - hitN = (pN_state==9) && (prevN!=9).
  - blockN = (pN_state==10) && (prevN!=10).
  - Events are acted on only in FIGHT.
  - Previous-state registers update every cycle in every phase.
- IDLE:
  - start rising edge → COUNTDOWN.
  - On that edge: round_timer=COUNTDOWN_SEC, frame counter=0, healths, rounds and block counts cleared, winner=00.
- COUNTDOWN:
  - Frame counter counts 0..FRAMES_PER_SEC-1; on wrap, round_timer decrements.
  - When round_timer==1 and the counter wraps: → FIGHT, round_timer=ROUND_TIME, round_start pulses that cycle, freeze goes low on the next cycle.
- FIGHT:
  - hitN decrements pN_health, saturating at 0.
  - blockN increments pN_blocks, saturating at 255.
  - Simultaneous events on both players are both applied in the same cycle.
  - Timer decrements once per FRAMES_PER_SEC frames.
  - Round end is evaluated on the updated values; → ROUND_END when any of the following holds:
    - A player's health reaches 0: the other player wins. Both at 0 in the same cycle is a draw.
    - The timer reaches 0: the player with higher health wins; equal health is a draw.
  - Winner's rounds counter increments on entry to ROUND_END. A draw awards nothing.
- ROUND_END:
  - Hold ROUND_END_FRAMES frames.
  - Then, if either rounds counter equals ROUNDS_TO_WIN → MATCH_OVER with winner held.
  - Otherwise → COUNTDOWN with healths restored to MAX_HEALTH, round_timer=COUNTDOWN_SEC, winner=00.
- MATCH_OVER:
  - All outputs hold.
  - start rising edge → COUNTDOWN with the full clear described under IDLE.
- start edges are ignored in COUNTDOWN, FIGHT and ROUND_END.
- reset_n low at any time immediately restores all reset values, including mid-round and mid-countdown.
- Unknown state codes (11–15) are treated as non-stun.
- The frame counter never exceeds FRAMES_PER_SEC-1.

Test Plan:
- Reset, then start pulse → COUNTDOWN with round_timer 3; after 180 cycles game_phase=FIGHT, round_start high exactly one cycle, freeze=0, round_timer=99.
- In FIGHT, drive p2_state 0→9, hold 9 for 14 cycles, then 0→9 → p2_health 3→2 only once during the hold, then →1; p1_health stays 3.
- Three separate P2 hitstun entries → p2_health=0, winner=01, p1_rounds=1, ROUND_END; after 120 cycles COUNTDOWN with healths=3.
- Same-cycle entry of both players into 9 with both healths at 1 → both 0, winner=11, no round awarded.
- No hits for 99×60 cycles with p1_health=3, p2_health=2 → round_timer=0, winner=01. Second P1 round win → MATCH_OVER holding p1_rounds=2; start pulse → COUNTDOWN with all counts cleared.
- Assert reset_n low mid-FIGHT with p1_health=1 and p2_blocks=5 → all outputs return to reset values asynchronously; p2_state entering 10 during COUNTDOWN leaves p2_blocks unchanged.

Source files
------------

// File: rtl/match_controller.sv
// rtl/match_controller.sv - round/match sequencing, health, block counts and freeze for two players
module match_controller #(
  parameter int MAX_HEALTH       = 3,
  parameter int FRAMES_PER_SEC   = 60,
  parameter int ROUND_TIME       = 99,
  parameter int COUNTDOWN_SEC    = 3,
  parameter int ROUND_END_FRAMES = 120,
  parameter int ROUNDS_TO_WIN    = 2
) (
  input  logic       clk_60Hz,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [6:0] round_timer,
  output logic [2:0] game_phase,
  output logic [1:0] winner,
  output logic       freeze,
  output logic       round_start,
  output logic [7:0] p1_blocks,
  output logic [7:0] p2_blocks
);

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_COUNTDOWN  = 3'd1,
    PH_FIGHT      = 3'd2,
    PH_ROUND_END  = 3'd3,
    PH_MATCH_OVER = 3'd4
  } phase_e;

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int RW = (ROUND_END_FRAMES > 1) ? $clog2(ROUND_END_FRAMES) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [RW-1:0] HOLD_LAST  = RW'(ROUND_END_FRAMES - 1);
  localparam logic [2:0]    HEALTH_MAX = 3'(MAX_HEALTH);
  localparam logic [6:0]    T_ROUND    = 7'(ROUND_TIME);
  localparam logic [6:0]    T_COUNT    = 7'(COUNTDOWN_SEC);
  localparam logic [1:0]    WIN_ROUNDS = 2'(ROUNDS_TO_WIN);
  localparam logic [3:0]    ST_HIT     = 4'd9;
  localparam logic [3:0]    ST_BLOCK   = 4'd10;

  phase_e        phase_q, phase_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [RW-1:0] hold_q, hold_d;
  logic [6:0]    timer_q, timer_d;
  logic [2:0]    h1_q, h1_d, h2_q, h2_d;
  logic [1:0]    r1_q, r1_d, r2_q, r2_d;
  logic [7:0]    b1_q, b1_d, b2_q, b2_d;
  logic [1:0]    win_q, win_d;
  logic          start_q;
  logic [3:0]    prev1_q, prev2_q;

  logic start_edge, hit1, hit2, blk1, blk2, frame_wrap;

  // Stun events are entry edges, so holding a stun state counts once.
  assign start_edge = start & ~start_q;
  assign hit1       = (p1_state == ST_HIT)   && (prev1_q != ST_HIT);
  assign hit2       = (p2_state == ST_HIT)   && (prev2_q != ST_HIT);
  assign blk1       = (p1_state == ST_BLOCK) && (prev1_q != ST_BLOCK);
  assign blk2       = (p2_state == ST_BLOCK) && (prev2_q != ST_BLOCK);
  assign frame_wrap = (frame_q == FRAME_LAST);

  always_comb begin
    phase_d     = phase_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    timer_d     = timer_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    win_d       = win_q;
    round_start = 1'b0;

    case (phase_q)
      PH_IDLE, PH_MATCH_OVER: begin
        if (start_edge) begin
          phase_d = PH_COUNTDOWN;
          timer_d = T_COUNT;
          frame_d = '0;
          h1_d    = HEALTH_MAX;
          h2_d    = HEALTH_MAX;
          r1_d    = 2'd0;
          r2_d    = 2'd0;
          b1_d    = 8'd0;
          b2_d    = 8'd0;
          win_d   = 2'b00;
        end
      end

      PH_COUNTDOWN: begin
        if (frame_wrap) begin
          frame_d = '0;
          if (timer_q == 7'd1) begin
            phase_d     = PH_FIGHT;
            timer_d     = T_ROUND;
            round_start = 1'b1;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end

      PH_FIGHT: begin
        if (hit1 && (h1_q != 3'd0)) h1_d = h1_q - 3'd1;
        if (hit2 && (h2_q != 3'd0)) h2_d = h2_q - 3'd1;
        if (blk1 && (b1_q != 8'hFF)) b1_d = b1_q + 8'd1;
        if (blk2 && (b2_q != 8'hFF)) b2_d = b2_q + 8'd1;

        if (frame_wrap) begin
          frame_d = '0;
          if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
        end else begin
          frame_d = frame_q + 1'b1;
        end

        // Decide on this cycle's updated health/timer, not the registered ones.
        if ((h1_d == 3'd0) || (h2_d == 3'd0) || (timer_d == 7'd0)) begin
          phase_d = PH_ROUND_END;
          hold_d  = '0;
          if ((h1_d == 3'd0) && (h2_d == 3'd0)) win_d = 2'b11;
          else if (h1_d == 3'd0)                win_d = 2'b10;
          else if (h2_d == 3'd0)                win_d = 2'b01;
          else if (h1_d > h2_d)                 win_d = 2'b01;
          else if (h2_d > h1_d)                 win_d = 2'b10;
          else                                  win_d = 2'b11;
          if (win_d == 2'b01)      r1_d = r1_q + 2'd1;
          else if (win_d == 2'b10) r2_d = r2_q + 2'd1;
        end
      end

      PH_ROUND_END: begin
        if (hold_q == HOLD_LAST) begin
          if ((r1_q == WIN_ROUNDS) || (r2_q == WIN_ROUNDS)) begin
            phase_d = PH_MATCH_OVER;
          end else begin
            phase_d = PH_COUNTDOWN;
            h1_d    = HEALTH_MAX;
            h2_d    = HEALTH_MAX;
            timer_d = T_COUNT;
            frame_d = '0;
            win_d   = 2'b00;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk_60Hz or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      frame_q <= '0;
      hold_q  <= '0;
      timer_q <= T_ROUND;
      h1_q    <= HEALTH_MAX;
      h2_q    <= HEALTH_MAX;
      r1_q    <= 2'd0;
      r2_q    <= 2'd0;
      b1_q    <= 8'd0;
      b2_q    <= 8'd0;
      win_q   <= 2'b00;
      start_q <= 1'b0;
      prev1_q <= 4'd0;
      prev2_q <= 4'd0;
    end else begin
      phase_q <= phase_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      win_q   <= win_d;
      start_q <= start;
      prev1_q <= p1_state;
      prev2_q <= p2_state;
    end
  end

  assign game_phase  = phase_q;
  assign freeze      = (phase_q != PH_FIGHT);
  assign round_timer = timer_q;
  assign p1_health   = h1_q;
  assign p2_health   = h2_q;
  assign p1_rounds   = r1_q;
  assign p2_rounds   = r2_q;
  assign p1_blocks   = b1_q;
  assign p2_blocks   = b2_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - match_controller against a tick-count reference model
module tb_match_controller;

  localparam int FPS = 60;
  localparam int RT  = 99;
  localparam int CDS = 3;
  localparam int REF = 120;
  localparam int MH  = 3;
  localparam int RTW = 2;

  logic       clk_60Hz = 1'b0;
  logic       reset_n  = 1'b1;
  logic       start    = 1'b0;
  logic [3:0] p1_state = 4'd0;
  logic [3:0] p2_state = 4'd0;
  logic [2:0] p1_health, p2_health, game_phase;
  logic [1:0] p1_rounds, p2_rounds, winner;
  logic [6:0] round_timer;
  logic       freeze, round_start;
  logic [7:0] p1_blocks, p2_blocks;

  match_controller dut (
    .clk_60Hz   (clk_60Hz),
    .reset_n    (reset_n),
    .start      (start),
    .p1_state   (p1_state),
    .p2_state   (p2_state),
    .p1_health  (p1_health),
    .p2_health  (p2_health),
    .p1_rounds  (p1_rounds),
    .p2_rounds  (p2_rounds),
    .round_timer(round_timer),
    .game_phase (game_phase),
    .winner     (winner),
    .freeze     (freeze),
    .round_start(round_start),
    .p1_blocks  (p1_blocks),
    .p2_blocks  (p2_blocks)
  );

  always #5 clk_60Hz = ~clk_60Hz;

  int checks   = 0;
  int failures = 0;
  int rs_count = 0;

  // Model: phase plus cycles spent in it; timers are derived from the tick count.
  int m_phase, m_tick, m_end_timer, m_h1, m_h2, m_r1, m_r2, m_b1, m_b2, m_win;
  int m_start, m_prev1, m_prev2;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_tick = 0; m_end_timer = RT;
    m_h1 = MH; m_h2 = MH; m_r1 = 0; m_r2 = 0; m_b1 = 0; m_b2 = 0; m_win = 0;
    m_start = 0; m_prev1 = 0; m_prev2 = 0;
  endtask

  function automatic int exp_timer();
    case (m_phase)
      0:       return RT;
      1:       return CDS - m_tick / FPS;
      2:       return RT - m_tick / FPS;
      default: return m_end_timer;
    endcase
  endfunction

  task automatic full_clear();
    m_phase = 1; m_tick = 0;
    m_h1 = MH; m_h2 = MH; m_r1 = 0; m_r2 = 0; m_b1 = 0; m_b2 = 0; m_win = 0;
  endtask

  task automatic model_step(input int s, input int a, input int b);
    bit hit1, hit2, blk1, blk2, edge_s;
    int t;
    hit1   = (a == 9)  && (m_prev1 != 9);
    hit2   = (b == 9)  && (m_prev2 != 9);
    blk1   = (a == 10) && (m_prev1 != 10);
    blk2   = (b == 10) && (m_prev2 != 10);
    edge_s = (s != 0) && (m_start == 0);
    case (m_phase)
      0, 4: if (edge_s) full_clear();
      1: begin
        m_tick++;
        if (m_tick == CDS * FPS) begin m_phase = 2; m_tick = 0; end
      end
      2: begin
        if (hit1 && m_h1 > 0) m_h1--;
        if (hit2 && m_h2 > 0) m_h2--;
        if (blk1 && m_b1 < 255) m_b1++;
        if (blk2 && m_b2 < 255) m_b2++;
        m_tick++;
        t = RT - m_tick / FPS;
        if (m_h1 == 0 || m_h2 == 0 || t == 0) begin
          m_phase = 3; m_tick = 0; m_end_timer = t;
          if (m_h1 == 0 && m_h2 == 0) m_win = 3;
          else if (m_h1 == 0)         m_win = 2;
          else if (m_h2 == 0)         m_win = 1;
          else if (m_h1 > m_h2)       m_win = 1;
          else if (m_h2 > m_h1)       m_win = 2;
          else                        m_win = 3;
          if (m_win == 1) m_r1++;
          if (m_win == 2) m_r2++;
        end
      end
      3: begin
        m_tick++;
        if (m_tick == REF) begin
          if (m_r1 == RTW || m_r2 == RTW) m_phase = 4;
          else begin m_phase = 1; m_tick = 0; m_h1 = MH; m_h2 = MH; m_win = 0; end
        end
      end
      default: ;
    endcase
    m_start = s; m_prev1 = a; m_prev2 = b;
  endtask

  task automatic check_all();
    check_eq("game_phase",  game_phase,  m_phase);
    check_eq("freeze",      freeze,      (m_phase != 2) ? 1 : 0);
    check_eq("round_start", round_start, (m_phase == 1 && m_tick == CDS * FPS - 1) ? 1 : 0);
    check_eq("round_timer", round_timer, exp_timer());
    check_eq("p1_health",   p1_health,   m_h1);
    check_eq("p2_health",   p2_health,   m_h2);
    check_eq("p1_rounds",   p1_rounds,   m_r1);
    check_eq("p2_rounds",   p2_rounds,   m_r2);
    check_eq("p1_blocks",   p1_blocks,   m_b1);
    check_eq("p2_blocks",   p2_blocks,   m_b2);
    check_eq("winner",      winner,      m_win);
  endtask

  task automatic step(input int s, input int a, input int b);
    start = (s != 0); p1_state = 4'(a); p2_state = 4'(b);
    @(posedge clk_60Hz);
    model_step(s, a, b);
    @(negedge clk_60Hz);
    if (round_start) rs_count++;
    check_all();
  endtask

  function automatic int rand_state();
    case ($urandom_range(0, 9))
      0:       return 9;
      1:       return 10;
      2:       return $urandom_range(11, 15);
      default: return $urandom_range(0, 8);
    endcase
  endfunction

  task automatic run_until(input int target, input int bound, input bit rnd);
    int n = 0;
    while (m_phase != target && n < bound) begin
      if (rnd) step(0, rand_state(), rand_state());
      else     step(0, 0, 0);
      n++;
    end
    check_eq("reach_phase", game_phase, target);
  endtask

  task automatic async_reset();
    start = 1'b0; p1_state = 4'd0; p2_state = 4'd0;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk_60Hz);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #1 check_all();
    @(negedge clk_60Hz);
    reset_n = 1'b1;
    repeat (3) step(0, 0, 0);

    // Countdown into the first fight.
    step(1, 0, 0);
    check_eq("cd_timer", round_timer, CDS);
    rs_count = 0;
    repeat (CDS * FPS) step(0, 0, 0);
    check_eq("fight_phase", game_phase, 2);
    check_eq("fight_freeze", freeze, 0);
    check_eq("fight_timer", round_timer, RT);
    check_eq("round_start_pulses", rs_count, 1);

    // A held hitstun costs one health only.
    step(0, 0, 9);
    repeat (14) step(0, 0, 9);
    check_eq("hold_p2_health", p2_health, 2);
    step(0, 0, 0);
    step(0, 0, 9);
    check_eq("rehit_p2_health", p2_health, 1);
    check_eq("rehit_p1_health", p1_health, 3);
    step(0, 0, 0);
    step(0, 0, 9);
    check_eq("ko_winner", winner, 1);
    check_eq("ko_p1_rounds", p1_rounds, 1);
    check_eq("ko_phase", game_phase, 3);
    run_until(1, REF + 5, 0);
    check_eq("restore_p2_health", p2_health, MH);

    // Blockstun during countdown is ignored; then a double-KO draw.
    step(0, 0, 10);
    step(0, 10, 10);
    check_eq("cd_p2_blocks", p2_blocks, 0);
    run_until(2, CDS * FPS + 5, 0);
    step(0, 10, 10);
    step(0, 9, 9);
    step(0, 10, 0);
    step(0, 9, 9);
    check_eq("both_one_p1", p1_health, 1);
    check_eq("both_one_p2", p2_health, 1);
    step(0, 0, 0);
    step(0, 9, 9);
    check_eq("draw_winner", winner, 3);
    check_eq("draw_p1_rounds", p1_rounds, 1);
    check_eq("draw_p2_rounds", p2_rounds, 0);
    run_until(1, REF + 5, 0);
    run_until(2, CDS * FPS + 5, 0);

    // Timer expiry decided on health, then match over.
    step(0, 0, 9);
    run_until(3, RT * FPS + 5, 0);
    check_eq("timeout_timer", round_timer, 0);
    check_eq("timeout_winner", winner, 1);
    run_until(4, REF + 5, 0);
    check_eq("match_p1_rounds", p1_rounds, 2);
    repeat (5) step(0, rand_state(), rand_state());
    step(1, 0, 0);
    check_eq("restart_phase", game_phase, 1);
    check_eq("restart_p1_rounds", p1_rounds, 0);
    check_eq("restart_p1_blocks", p1_blocks, 0);

    // Random play, including start presses in every phase.
    repeat (3000) step(($urandom_range(0, 49) == 0) ? 1 : 0, rand_state(), rand_state());

    // Asynchronous reset in the middle of a fight.
    async_reset();
    step(1, 0, 0);
    run_until(2, CDS * FPS + 5, 0);
    step(0, 9, 0);
    step(0, 0, 0);
    step(0, 9, 0);
    repeat (5) begin
      step(0, 0, 10);
      step(0, 0, 0);
    end
    check_eq("pre_rst_p1_health", p1_health, 1);
    check_eq("pre_rst_p2_blocks", p2_blocks, 5);
    async_reset();
    check_eq("rst_p2_blocks", p2_blocks, 0);
    repeat (4) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
